// File: rtl/ftsd_scan_ctl_if.sv
// Handshake/bus bundle between a display-value producer and ftsd_scan_ctl.
// master = producer (drives load/digits_in), slave = scan controller.
interface ftsd_scan_ctl_if #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned BCD_W  = 4
);
   logic                      load;
   logic [DIGITS*BCD_W-1:0]   digits_in;
   logic [BCD_W-1:0]          bcd_out;
   logic [DIGITS-1:0]         ftsd_ctl;
   logic                      frame_done;
   logic                      pending;

   modport master (
      output load, digits_in,
      input  bcd_out, ftsd_ctl, frame_done, pending
   );

   modport slave (
      input  load, digits_in,
      output bcd_out, ftsd_ctl, frame_done, pending
   );
endinterface

// File: rtl/ftsd_scan_ctl.sv
// Time-multiplexed, double-buffered scan controller for a multi-digit 14-segment panel.
// Optional leading-zero blanking is enabled by defining FTSD_SCAN_LZB_EN.
module ftsd_scan_ctl #(
   parameter int unsigned      DIGITS       = 4,
   parameter int unsigned      BCD_W        = 4,
   parameter int unsigned      CNT_W        = 16,
   parameter logic [CNT_W-1:0] SCAN_CNT_MAX = 16'd49999
) (
   input logic            clk,
   input logic            rst_n,
   ftsd_scan_ctl_if.slave bus
);

   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned VAL_W = DIGITS * BCD_W;

   typedef logic [IDX_W-1:0] idx_t;
   localparam idx_t LAST = idx_t'(DIGITS - 1);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   idx_t              idx_q, idx_d;
   logic [VAL_W-1:0]  shadow_q, shadow_d;
   logic [VAL_W-1:0]  disp_q, disp_d;
   logic              pending_q, pending_d;
   logic [BCD_W-1:0]  bcd_q, bcd_d;
   logic [DIGITS-1:0] ftsd_q, ftsd_d;
   logic              frame_done_q, frame_done_d;

   logic              tick;
   logic              boundary;
   idx_t              nidx;
   logic [BCD_W-1:0]  sel_val;
   logic [DIGITS-1:0] sel_ctl;
`ifdef FTSD_SCAN_LZB_EN
   logic              lead_zero;
`endif

   always_comb begin
      tick     = (cnt_q == SCAN_CNT_MAX);
      boundary = tick && (idx_q == LAST);
      cnt_d    = tick ? '0 : cnt_q + 1'b1;
      nidx     = boundary ? '0 : idx_q + 1'b1;
      idx_d    = tick ? nidx : idx_q;

      shadow_d = bus.load ? bus.digits_in : shadow_q;

      // A load on the boundary edge bypasses the shadow so it shows on that same edge.
      disp_d = disp_q;
      if (boundary && bus.load)
         disp_d = bus.digits_in;
      else if (boundary && pending_q)
         disp_d = shadow_q;

      pending_d = pending_q;
      if (boundary)
         pending_d = 1'b0;
      else if (bus.load)
         pending_d = 1'b1;

      sel_val = '0;
      sel_ctl = '1;
`ifdef FTSD_SCAN_LZB_EN
      lead_zero = 1'b1;
`endif
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (nidx == idx_t'(i)) begin
            sel_val    = disp_d[i*BCD_W +: BCD_W];
            sel_ctl[i] = 1'b0;
         end
`ifdef FTSD_SCAN_LZB_EN
         if ((idx_t'(i) >= nidx) && (disp_d[i*BCD_W +: BCD_W] != '0))
            lead_zero = 1'b0;
`endif
      end
`ifdef FTSD_SCAN_LZB_EN
      if ((nidx != '0) && lead_zero)
         sel_ctl = '1;
`endif

      bcd_d        = tick ? sel_val : bcd_q;
      ftsd_d       = tick ? sel_ctl : ftsd_q;
      frame_done_d = boundary;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         shadow_q     <= '0;
         disp_q       <= '0;
         pending_q    <= 1'b0;
         bcd_q        <= '0;
         ftsd_q       <= '1;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         disp_q       <= disp_d;
         pending_q    <= pending_d;
         bcd_q        <= bcd_d;
         ftsd_q       <= ftsd_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.bcd_out    = bcd_q;
   assign bus.ftsd_ctl   = ftsd_q;
   assign bus.pending    = pending_q;
   assign bus.frame_done = frame_done_q;

endmodule
